multicycle_controller: RTL and testbench
========================================

MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 SHALL have the following ports, listed as name, direction, width, meaning:
  clk         in   1  single clock, rising edge
  rst_n       in   1  asynchronous, active-low reset
  opcode      in   7  instruction opcode (IR[6:0])
  func3       in   3  IR[14:12]
  func7_5     in   1  IR[30]
  zero        in   1  ALU zero flag
  mem_ready   in   1  memory access complete, same cycle
  PCWrite     out  1  PC register enable
  AdrSrc      out  1  memory address: 0=PC, 1=ALUOut
  MemWrite    out  1  memory write strobe
  IRWrite     out  1  IR and OldPC enable
  RegWrite    out  1  register file write enable
  ResultSrc   out  2  00=ALUOut, 01=Data, 10=ALUResult
  ALUSrcA     out  2  00=PC, 01=OldPC, 10=rs1
  ALUSrcB     out  2  00=rs2, 01=imm, 10=constant 4
  ImmSrc      out  2  00=I, 01=S, 10=B, 11=J
  ALUControl  out  3  000 add, 001 sub, 010 and, 011 or, 100 xor, 101 slt, 110 srl
  illegal     out  1  one-cycle pulse on an unsupported opcode
  state       out  4  current state, for debug

Function
REQ-002 SHALL use a Moore FSM with these state encodings: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECR=6, EXECI=7, ALUWB=8, BEQ=9, JAL=10.
REQ-003 FETCH: AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALU op add, ResultSrc=10; IRWrite=PCWrite=mem_ready; SHALL stay in FETCH while mem_ready=0, otherwise go to DECODE.
REQ-004 DECODE: ALUSrcA=01, ALUSrcB=01, ALU op add (branch target). Next state by opcode:
  0000011 or 0100011 -> MEMADR
  0110011 -> EXECR
  0010011 -> EXECI
  1100011 -> BEQ
  1101111 -> JAL (see REQ-015)
  any other opcode -> FETCH with illegal=1
REQ-005 MEMADR: ALUSrcA=10, ALUSrcB=01, ALU op add; next state MEMREAD if opcode=0000011, else MEMWRITE.
REQ-006 MEMREAD: AdrSrc=1, ResultSrc=00; SHALL hold until mem_ready=1, then go to MEMWB.
REQ-007 MEMWB: ResultSrc=01, RegWrite=1; next state FETCH.
REQ-008 MEMWRITE: AdrSrc=1, ResultSrc=00, MemWrite=1; SHALL hold MemWrite high until the cycle mem_ready=1 inclusive, then go to FETCH.
REQ-009 EXECR: ALUSrcA=10, ALUSrcB=00, func3 decode. EXECI: ALUSrcA=10, ALUSrcB=01, func3 decode. Both SHALL go to ALUWB.
REQ-010 ALUWB: ResultSrc=00, RegWrite=1; next state FETCH.
REQ-011 BEQ: ALUSrcA=10, ALUSrcB=00, ALU op sub, ResultSrc=00, PCWrite=zero; next state FETCH.
REQ-012 func3 decode SHALL map as follows:
  000: sub only when opcode=0110011 and func7_5=1; add otherwise, including func7_5=x on I-type
  010 -> slt, 100 -> xor, 101 -> srl, 110 -> or, 111 -> and
  001 or 011 -> add with illegal=1
REQ-013 ImmSrc SHALL be combinational from opcode in every state: load/addi=00, store=01, branch=10, jal=11, other=00.
REQ-014 In every state, any output not listed for that state SHALL be 0.
  - Latency: lw=5 cycles, sw=4, R/I-type=4, beq=3, jal=4, each plus memory wait cycles.

Reset
REQ-016 rst_n=0 SHALL force state=FETCH asynchronously, including mid-instruction, with all strobes deasserted and no partial RegWrite or MemWrite.
REQ-017 After rst_n deasserts, the first clk edge SHALL evaluate FETCH; the outputs during reset are the FETCH decode with mem_ready forced to 0.

Configuration
REQ-015 With JAL_EN defined, the JAL state SHALL be compiled in: ALUSrcA=01, ALUSrcB=10, ALU op add, ResultSrc=00, PCWrite=1; next state ALUWB, so rd receives OldPC+4.
REQ-018 Without JAL_EN, opcode 1101111 SHALL be treated as illegal (REQ-004) and state 10 SHALL be unreachable.

Verification
REQ-019 lw (0000011/010), mem_ready tied 1 -> state sequence 0,1,2,3,4,0; RegWrite=1 only in state 4 with ResultSrc=01.
REQ-020 sw (0100011/010), mem_ready low 2 cycles in MEMWRITE -> MemWrite high for 3 cycles, then FETCH; RegWrite never 1.
REQ-021 beq with zero=0, then again with zero=1 -> PCWrite in BEQ is 0, then 1; ALUControl=001 in both cases.
REQ-022 sub (0110011/000, func7_5=1) -> ALUControl=001; srl (101) -> 110; xor (100) -> 100; addi with func7_5=x -> 000; each followed by ALUWB with RegWrite=1.
REQ-023 opcode 0000000 in DECODE -> illegal=1 for one cycle, then FETCH; rst_n pulsed low during MEMREAD -> state=0 immediately, with no RegWrite.
REQ-024 jal (1101111) -> with JAL_EN: states 1,10,8 and PCWrite=1 in state 10; without JAL_EN: illegal=1.

Source files
------------

// File: rtl/multicycle_controller.sv
// Multicycle RV32 subset control FSM: fetch/decode/memory/ALU/branch sequencing.
// Optional macro JAL_EN compiles in the JAL state; without it jal decodes as illegal.
module multicycle_controller (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] opcode,
  input  logic [2:0] func3,
  input  logic       func7_5,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ImmSrc,
  output logic [2:0] ALUControl,
  output logic       illegal,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10
  } state_t;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b101;
  localparam logic [2:0] ALU_SRL = 3'b110;

  state_t state_q, state_d;
  logic   mem_rdy;
  logic [2:0] exec_alu;
  logic       exec_ill;

  // Holding reset forces the FETCH strobes low even if memory reports ready.
  assign mem_rdy = mem_ready & rst_n;
  assign state   = state_q;

  // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  always_comb begin
    ImmSrc = 2'b00;
    unique case (opcode)
      OP_STORE: ImmSrc = 2'b01;
      OP_BR:    ImmSrc = 2'b10;
      OP_JAL:   ImmSrc = 2'b11;
      default:  ImmSrc = 2'b00;
    endcase
  end

  always_comb begin
    exec_alu = ALU_ADD;
    exec_ill = 1'b0;
    case (func3)
      3'b000:  exec_alu = (opcode == OP_R && func7_5) ? ALU_SUB : ALU_ADD;
      3'b010:  exec_alu = ALU_SLT;
      3'b100:  exec_alu = ALU_XOR;
      3'b101:  exec_alu = ALU_SRL;
      3'b110:  exec_alu = ALU_OR;
      3'b111:  exec_alu = ALU_AND;
      default: exec_ill = 1'b1;
    endcase
  end

  // NOTE: every output gets a default first so no path through the case infers a latch.
  always_comb begin
    state_d    = state_q;
    PCWrite    = 1'b0;
    AdrSrc     = 1'b0;
    MemWrite   = 1'b0;
    IRWrite    = 1'b0;
    RegWrite   = 1'b0;
    ResultSrc  = 2'b00;
    ALUSrcA    = 2'b00;
    ALUSrcB    = 2'b00;
    ALUControl = ALU_ADD;
    illegal    = 1'b0;
    case (state_q)
      S_FETCH: begin
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        IRWrite   = mem_rdy;
        PCWrite   = mem_rdy;
        if (mem_rdy) state_d = S_DECODE;
      end
      S_DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        case (opcode)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_R:              state_d = S_EXECR;
          OP_I:              state_d = S_EXECI;
          OP_BR:             state_d = S_BEQ;
`ifdef JAL_EN
          OP_JAL:            state_d = S_JAL;
`endif
          default: begin
            state_d = S_FETCH;
            illegal = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        state_d = (opcode == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        AdrSrc = 1'b1;
        if (mem_rdy) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        ResultSrc = 2'b01;
        RegWrite  = 1'b1;
        state_d   = S_FETCH;
      end
      S_MEMWRITE: begin
        AdrSrc   = 1'b1;
        MemWrite = 1'b1;
        if (mem_rdy) state_d = S_FETCH;
      end
      S_EXECR, S_EXECI: begin
        ALUSrcA    = 2'b10;
        ALUSrcB    = (state_q == S_EXECI) ? 2'b01 : 2'b00;
        ALUControl = exec_alu;
        illegal    = exec_ill;
        state_d    = S_ALUWB;
      end
      S_ALUWB: begin
        RegWrite = 1'b1;
        state_d  = S_FETCH;
      end
      S_BEQ: begin
        ALUSrcA    = 2'b10;
        ALUControl = ALU_SUB;
        PCWrite    = zero;
        state_d    = S_FETCH;
      end
`ifdef JAL_EN
      S_JAL: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b10;
        PCWrite = 1'b1;
        state_d = S_ALUWB;
      end
`endif
      default: state_d = S_FETCH;
    endcase
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for multicycle_controller: per-instruction expected cycle traces
// from a behavioural instruction model, checked by an independent negedge monitor.
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] opcode;
  logic [2:0] func3;
  logic       func7_5;
  logic       zero;
  logic       mem_ready;
  logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, illegal;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
  logic [2:0] ALUControl;
  logic [3:0] state;

  multicycle_controller dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .func3(func3), .func7_5(func7_5),
    .zero(zero), .mem_ready(mem_ready), .PCWrite(PCWrite), .AdrSrc(AdrSrc),
    .MemWrite(MemWrite), .IRWrite(IRWrite), .RegWrite(RegWrite), .ResultSrc(ResultSrc),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc), .ALUControl(ALUControl),
    .illegal(illegal), .state(state)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] st;
    logic       pcw, adr, mw, irw, rw;
    logic [1:0] rs, sa, sb, imm;
    logic [2:0] alu;
    logic       ill;
  } exp_t;

  typedef struct packed {
    logic [6:0] op;
    logic [2:0] f3;
    logic       f75, z, mr;
  } stim_t;

  exp_t  exp_q[$];
  stim_t stim_q[$];
  int    checks = 0;
  int    failures = 0;
  bit    chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, got, want);
    end
  endtask

  function automatic exp_t dut_now();
    return '{st:state, pcw:PCWrite, adr:AdrSrc, mw:MemWrite, irw:IRWrite, rw:RegWrite,
             rs:ResultSrc, sa:ALUSrcA, sb:ALUSrcB, imm:ImmSrc, alu:ALUControl, ill:illegal};
  endfunction

  // Monitor: one expected record per cycle, compared mid-cycle.
  always @(negedge clk) begin
    if (chk_en && exp_q.size() > 0) begin
      exp_t want, got;
      want = exp_q.pop_front();
      got  = dut_now();
      checks++;
      if (got !== want) begin
        failures++;
        $display("FAIL cycle op=%b got=%h exp=%h", opcode, got, want);
      end
    end
  end

  // ---------------- reference model ----------------
  logic [6:0] cur_op;
  logic [2:0] cur_f3;
  logic       cur_f75;

  function automatic exp_t blank(input int st);
    exp_t e;
    e = '0;
    e.st = 4'(st);
    case (cur_op)
      7'b0100011: e.imm = 2'd1;
      7'b1100011: e.imm = 2'd2;
      7'b1101111: e.imm = 2'd3;
      default:    e.imm = 2'd0;
    endcase
    return e;
  endfunction

  task automatic emit(input exp_t e, input logic mr, input logic z);
    exp_q.push_back(e);
    stim_q.push_back('{op:cur_op, f3:cur_f3, f75:cur_f75, z:z, mr:mr});
  endtask

  function automatic logic rnd();
    return 1'($urandom_range(0, 1));
  endfunction

  // Instruction -> list of per-cycle control words, from the instruction's semantics.
  task automatic issue(input logic [6:0] op, input logic [2:0] f3, input logic f75,
                       input logic zv, input int fwait, input int mwait);
    exp_t e;
    bit jal_ok;
`ifdef JAL_EN
    jal_ok = 1'b1;
`else
    jal_ok = 1'b0;
`endif
    cur_op = op; cur_f3 = f3; cur_f75 = f75;
    for (int i = 0; i <= fwait; i++) begin
      e = blank(0); e.sb = 2'd2; e.rs = 2'd2;
      e.irw = (i == fwait); e.pcw = (i == fwait);
      emit(e, (i == fwait), rnd());
    end
    e = blank(1); e.sa = 2'd1; e.sb = 2'd1;
    if (!(op inside {7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011}) &&
        !(op == 7'b1101111 && jal_ok)) begin
      e.ill = 1'b1;
      emit(e, rnd(), rnd());
      return;
    end
    emit(e, rnd(), rnd());
    if (op == 7'b0000011 || op == 7'b0100011) begin
      e = blank(2); e.sa = 2'd2; e.sb = 2'd1;
      emit(e, rnd(), rnd());
      for (int i = 0; i <= mwait; i++) begin
        e = blank(op == 7'b0000011 ? 3 : 5); e.adr = 1'b1; e.mw = (op == 7'b0100011);
        emit(e, (i == mwait), rnd());
      end
      if (op == 7'b0000011) begin
        e = blank(4); e.rs = 2'd1; e.rw = 1'b1;
        emit(e, rnd(), rnd());
      end
    end else if (op == 7'b1100011) begin
      e = blank(9); e.sa = 2'd2; e.alu = 3'd1; e.pcw = zv;
      emit(e, rnd(), zv);
    end else begin
      if (op == 7'b1101111) begin
        e = blank(10); e.sa = 2'd1; e.sb = 2'd2; e.pcw = 1'b1;
      end else begin
        e = blank(op == 7'b0110011 ? 6 : 7); e.sa = 2'd2;
        e.sb = (op == 7'b0010011) ? 2'd1 : 2'd0;
        case (f3)
          3'd0: e.alu = (op == 7'b0110011 && f75) ? 3'd1 : 3'd0;
          3'd2: e.alu = 3'd5;
          3'd4: e.alu = 3'd4;
          3'd5: e.alu = 3'd6;
          3'd6: e.alu = 3'd3;
          3'd7: e.alu = 3'd2;
          default: begin e.alu = 3'd0; e.ill = 1'b1; end
        endcase
      end
      emit(e, rnd(), rnd());
      e = blank(8); e.rw = 1'b1;
      emit(e, rnd(), rnd());
    end
  endtask

  task automatic drive_all();
    stim_t s;
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front();
      opcode = s.op; func3 = s.f3; func7_5 = s.f75; zero = s.z; mem_ready = s.mr;
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  localparam logic [6:0] OPS [0:7] = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011,
                                       7'b1100011, 7'b1101111, 7'b0000000, 7'b1110011};

  initial begin
    int budget;
    rst_n = 1'b0; opcode = 7'b0000011; func3 = 3'd2; func7_5 = 1'b0;
    zero = 1'b0; mem_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    // Reset outputs: FETCH decode with mem_ready masked.
    check("rst_state", 32'(state), 32'd0);
    check("rst_irwrite", 32'(IRWrite), 32'd0);
    check("rst_pcwrite", 32'(PCWrite), 32'd0);
    check("rst_srcb", 32'(ALUSrcB), 32'd2);
    check("rst_result", 32'(ResultSrc), 32'd2);
    check("rst_strobes", 32'({RegWrite, MemWrite, AdrSrc}), 32'd0);
    mem_ready = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk_en = 1'b1;

    issue(7'b0000011, 3'd2, 1'b0, 1'b0, 0, 0);   // lw, no waits
    issue(7'b0100011, 3'd2, 1'b0, 1'b0, 0, 2);   // sw, 2 wait cycles
    issue(7'b1100011, 3'd0, 1'b0, 1'b0, 0, 0);   // beq not taken
    issue(7'b1100011, 3'd0, 1'b0, 1'b1, 1, 0);   // beq taken
    issue(7'b0110011, 3'd0, 1'b1, 1'b0, 0, 0);   // sub
    issue(7'b0110011, 3'd5, 1'b0, 1'b0, 0, 0);   // srl
    issue(7'b0110011, 3'd4, 1'b0, 1'b0, 0, 0);   // xor
    issue(7'b0010011, 3'd0, 1'b1, 1'b0, 0, 0);   // addi with IR[30] set
    issue(7'b0010011, 3'd1, 1'b0, 1'b0, 0, 0);   // unsupported func3
    issue(7'b0000000, 3'd0, 1'b0, 1'b0, 0, 0);   // illegal opcode
    issue(7'b1101111, 3'd0, 1'b0, 1'b0, 0, 0);   // jal
    drive_all();
    for (int n = 0; n < 60; n++) begin
      issue(OPS[$urandom_range(0, 7)], 3'($urandom_range(0, 7)), rnd(), rnd(),
            $urandom_range(0, 2), $urandom_range(0, 3));
      drive_all();
    end
    budget = 0;
    while (exp_q.size() > 0 && budget < 10) begin
      @(posedge clk); #1;
      budget++;
    end
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    chk_en = 1'b0;

    // Asynchronous reset while waiting in MEMREAD.
    opcode = 7'b0000011; func3 = 3'd2; mem_ready = 1'b1;
    budget = 0;
    while (state != 4'd3 && budget < 20) begin
      @(posedge clk); #1;
      budget++;
      if (state == 4'd3) mem_ready = 1'b0;
    end
    check("reach_memread", 32'(state), 32'd3);
    @(negedge clk);
    mem_ready = 1'b1;
    rst_n = 1'b0;
    #1;
    check("async_rst_state", 32'(state), 32'd0);
    check("async_rst_regwrite", 32'(RegWrite), 32'd0);
    check("async_rst_irwrite", 32'(IRWrite), 32'd0);
    @(posedge clk); #1;
    check("rst_hold_state", 32'(state), 32'd0);
    check("rst_hold_strobes", 32'({RegWrite, MemWrite, PCWrite}), 32'd0);
    rst_n = 1'b1;
    #1;
    check("post_rst_irwrite", 32'(IRWrite), 32'd1);
    @(posedge clk); #1;
    check("post_rst_decode", 32'(state), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
